scpad_tile_seq: RTL and testbench
=================================

SCPAD_TILE_SEQ -- requirements
Module: scpad_tile_seq

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of requesters sharing the address-map/crossbar path, at least 2.
REQ-002 SHALL have one clock; reset is synchronous and active-high. Ports: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-003 SHALL have req_valid input [NUM_REQ], per-requester tile request valid.
REQ-004 SHALL have req_ready output [NUM_REQ], per-requester request accepted this cycle.
REQ-005 SHALL have req_desc input [NUM_REQ] of tile_req_t: row_or_col, spad_addr[ROW_IDX_WIDTH], num_rows[MAX_DIM_WIDTH+1], num_cols[MAX_DIM_WIDTH+1].
REQ-006 SHALL have req_done output [NUM_REQ], one-cycle pulse when the owner's tile completes.
REQ-007 SHALL have am_row_or_col output 1, am_spad_addr output ROW_IDX_WIDTH, am_num_rows/am_num_cols output MAX_DIM_WIDTH+1, am_row_id/am_col_id output MAX_DIM_WIDTH; all drive the address-map inputs.
REQ-008 SHALL have beat_valid output 1, beat_ready input 1, beat_last output 1 and beat_src output clog2(NUM_REQ); together these form the crossbar beat handshake.

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE, DONE.
REQ-010 In IDLE, SHALL grant round-robin among asserted req_valid, starting after last_grant; req_ready[g] SHALL be high only in IDLE for the granted g, combinationally.
REQ-011 On acceptance, SHALL latch req_desc[g] and owner=g, set last_grant=g and idx=0; total = num_rows if row_or_col=1, else num_cols.
REQ-012 If total==0, SHALL go IDLE->DONE with no beats; otherwise IDLE->ISSUE.
REQ-013 Latency: for a request accepted at edge N, beat_valid SHALL be high in cycle N+1.
REQ-014 In ISSUE, beat_valid=1; am_row_id=idx when row_or_col=1, else am_col_id=idx; the unused id SHALL be 0.
REQ-015 In ISSUE, am_* static fields SHALL equal the latched request, and beat_src SHALL equal owner.
REQ-016 While beat_valid && !beat_ready, SHALL hold idx and all outputs stable.
REQ-017 On beat_valid && beat_ready, idx SHALL increment; beat_last SHALL be (idx==total-1).
REQ-018 A handshake with beat_last=1 SHALL move the FSM to DONE.
REQ-019 DONE SHALL last exactly one cycle, assert req_done[owner], then return to IDLE; minimum gap between tiles is 2 idle beat cycles.
REQ-020 A new request SHALL NOT be accepted outside IDLE; requests pending during ISSUE/DONE SHALL wait and not be dropped.
REQ-021 idx SHALL be MAX_DIM_WIDTH bits and SHALL never exceed total-1; spad_addr overflow is the address map's modulo concern, and no range check SHALL be performed.
REQ-022 beat_valid, req_done and req_ready SHALL all be 0 in IDLE when no req_valid is asserted.

Reset
REQ-023 With rst high at an edge, SHALL set state=IDLE, idx=0, owner=0, last_grant=NUM_REQ-1 so requester 0 wins first, and set all am_* outputs to 0.
REQ-024 Reset during ISSUE SHALL abort the tile: beat_valid low after that edge, with no req_done pulse.

Structure
REQ-025 tile_req_t and seq_state_t SHALL be defined in scpad_types_pkg, with existing NUM_COLS, MAX_DIM_WIDTH and ROW_IDX_WIDTH reused from it.
REQ-026 Round-robin grant logic SHALL be a sub-module scpad_rr_arb (req, last_grant -> one-hot grant, grant index), purely combinational.

Verification
REQ-027 Row-major tile spad_addr=8, num_rows=4, num_cols=32 from req 0, beat_ready=1 -> beats in cycles N+1..N+4 with am_row_id 0,1,2,3; beat_last on 4th; req_done[0] at N+5.
REQ-028 Column-major tile num_cols=3, beat_ready toggling 1,0,1,0,1 -> am_col_id 0,1,1,2,2; outputs held during stalls; exactly 3 handshakes.
REQ-029 req 0 and req 1 both valid continuously -> grants 0,1,0,1; beat_src matches owner; each req_done only to its owner.
REQ-030 num_rows=0 row-major -> no beat_valid; req_done pulse in cycle after acceptance.
REQ-031 rst asserted at 2nd beat of an 8-beat tile -> beat_valid 0 next cycle, no req_done; next request goes to req 0 first.
REQ-032 num_cols=32 column-major -> am_col_id reaches 31 with beat_last, no idx wrap, then DONE.

Source files
------------

// File: rtl/scpad_types_pkg.sv
// Shared scratchpad types: tile request descriptor, sequencer states and geometry constants.
package scpad_types_pkg;

  localparam int NUM_COLS      = 32;
  localparam int MAX_DIM_WIDTH = $clog2(NUM_COLS);
  localparam int ROW_IDX_WIDTH = 10;

  typedef struct packed {
    logic                     row_or_col;
    logic [ROW_IDX_WIDTH-1:0] spad_addr;
    logic [MAX_DIM_WIDTH:0]   num_rows;
    logic [MAX_DIM_WIDTH:0]   num_cols;
  } tile_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

  // Beat count of a tile: rows when row-major, columns otherwise.
  function automatic logic [MAX_DIM_WIDTH:0] tile_total(input tile_req_t d);
    return d.row_or_col ? d.num_rows : d.num_cols;
  endfunction

endpackage

// File: rtl/scpad_rr_arb.sv
// Combinational round-robin arbiter: the search starts one past last_grant and wraps.
module scpad_rr_arb #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_valid
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] cand_idx [NUM_REQ];

  // cand_idx[k] is the requester at priority position k after the last grant.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign cand_idx[gi] = IW'((int'(last_grant) + gi + 1) % NUM_REQ);
  end

  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    // Walk from lowest to highest priority so the last hit wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand_idx[k]]) begin
        grant_idx   = cand_idx[k];
        grant_valid = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign grant[gi] = grant_valid && (grant_idx == IW'(gi));
  end

endmodule

// File: rtl/scpad_tile_seq.sv
// Tile sequencer: arbitrates tile requests and walks a tile one row/column beat at a time.
module scpad_tile_seq
  import scpad_types_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  tile_req_t                    req_desc [NUM_REQ],
  output logic [NUM_REQ-1:0]           req_done,
  output logic                         am_row_or_col,
  output logic [ROW_IDX_WIDTH-1:0]     am_spad_addr,
  output logic [MAX_DIM_WIDTH:0]       am_num_rows,
  output logic [MAX_DIM_WIDTH:0]       am_num_cols,
  output logic [MAX_DIM_WIDTH-1:0]     am_row_id,
  output logic [MAX_DIM_WIDTH-1:0]     am_col_id,
  output logic                         beat_valid,
  input  logic                         beat_ready,
  output logic                         beat_last,
  output logic [$clog2(NUM_REQ)-1:0]   beat_src
);

  localparam int SW = $clog2(NUM_REQ);

  seq_state_t             state_reg, state_next;
  tile_req_t              desc_reg;
  logic [MAX_DIM_WIDTH:0] total_reg;
  logic [MAX_DIM_WIDTH-1:0] idx_reg;
  logic [SW-1:0]          owner_reg;
  logic [SW-1:0]          last_grant_reg;

  logic [NUM_REQ-1:0]     grant;
  logic [SW-1:0]          grant_idx;
  logic                   grant_valid;
  tile_req_t              sel_desc;
  logic                   accept;
  logic                   handshake;

  scpad_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  always_comb begin
    sel_desc = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == SW'(i)) sel_desc = req_desc[i];
    end
  end

  assign accept    = (state_reg == IDLE) && grant_valid;
  assign handshake = beat_valid && beat_ready;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = (tile_total(sel_desc) == '0) ? DONE : ISSUE;
      ISSUE:   if (handshake && beat_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // idx stops at total-1 so a full 32-beat tile never wraps the 5-bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      desc_reg       <= '0;
      total_reg      <= '0;
      idx_reg        <= '0;
      owner_reg      <= '0;
      last_grant_reg <= SW'(NUM_REQ - 1);
    end else if (accept) begin
      desc_reg       <= sel_desc;
      total_reg      <= tile_total(sel_desc);
      idx_reg        <= '0;
      owner_reg      <= grant_idx;
      last_grant_reg <= grant_idx;
    end else if (handshake && !beat_last) begin
      idx_reg        <= idx_reg + 1'b1;
    end
  end

  always_comb begin
    beat_valid    = (state_reg == ISSUE);
    beat_last     = beat_valid && ({1'b0, idx_reg} == total_reg - 1'b1);
    beat_src      = owner_reg;
    am_row_or_col = desc_reg.row_or_col;
    am_spad_addr  = desc_reg.spad_addr;
    am_num_rows   = desc_reg.num_rows;
    am_num_cols   = desc_reg.num_cols;
    am_row_id     = (beat_valid && desc_reg.row_or_col)  ? idx_reg : '0;
    am_col_id     = (beat_valid && !desc_reg.row_or_col) ? idx_reg : '0;
    req_ready     = accept ? grant : '0;
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_done
    assign req_done[gi] = (state_reg == DONE) && (owner_reg == SW'(gi));
  end

endmodule

// File: tb/tb_scpad_tile_seq.sv
// Directed and randomized tile sequences checked against a transaction-level model.
module tb_scpad_tile_seq;
  import scpad_types_pkg::*;

  localparam int N  = 3;
  localparam int SW = $clog2(N);

  logic                     clk;
  logic                     rst;
  logic [N-1:0]             req_valid;
  logic [N-1:0]             req_ready;
  tile_req_t                req_desc [N];
  logic [N-1:0]             req_done;
  logic                     am_row_or_col;
  logic [ROW_IDX_WIDTH-1:0] am_spad_addr;
  logic [MAX_DIM_WIDTH:0]   am_num_rows;
  logic [MAX_DIM_WIDTH:0]   am_num_cols;
  logic [MAX_DIM_WIDTH-1:0] am_row_id;
  logic [MAX_DIM_WIDTH-1:0] am_col_id;
  logic                     beat_valid;
  logic                     beat_ready;
  logic                     beat_last;
  logic [SW-1:0]            beat_src;

  int n_checks = 0;
  int n_fail   = 0;
  int model_last = N - 1;

  scpad_tile_seq #(.NUM_REQ(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_desc     (req_desc),
    .req_done     (req_done),
    .am_row_or_col(am_row_or_col),
    .am_spad_addr (am_spad_addr),
    .am_num_rows  (am_num_rows),
    .am_num_cols  (am_num_cols),
    .am_row_id    (am_row_id),
    .am_col_id    (am_col_id),
    .beat_valid   (beat_valid),
    .beat_ready   (beat_ready),
    .beat_last    (beat_last),
    .beat_src     (beat_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic tile_req_t mk(input bit roc, input int addr, input int rows, input int cols);
    tile_req_t d;
    d.row_or_col = roc;
    d.spad_addr  = ROW_IDX_WIDTH'(addr);
    d.num_rows   = (MAX_DIM_WIDTH + 1)'(rows);
    d.num_cols   = (MAX_DIM_WIDTH + 1)'(cols);
    return d;
  endfunction

  // Serve one tile: the winner is the first valid requester after the last winner.
  // Entered at a falling edge in IDLE with req_valid/req_desc already driven.
  // mode 0: beat_ready always 1, 1: toggling starting at 1, 2: random.
  task automatic serve(input bit keep, input int mode);
    int own;
    int total;
    int k;
    int cyc;
    tile_req_t d;
    logic [N-1:0] oh;
    own = -1;
    for (int o = 1; o <= N; o++) begin
      if (own < 0 && req_valid[(model_last + o) % N]) own = (model_last + o) % N;
    end
    if (own < 0) begin
      chk("no_requester_in_stimulus", 64'(req_valid), 64'd1);
      return;
    end
    d     = req_desc[own];
    total = d.row_or_col ? int'(d.num_rows) : int'(d.num_cols);
    oh    = '0;
    oh[own] = 1'b1;
    #1;
    chk("accept_ready", 64'(req_ready), 64'(oh));
    chk("idle_no_beat", 64'(beat_valid), 64'd0);
    chk("idle_no_done", 64'(req_done), 64'd0);
    model_last = own;
    @(negedge clk);
    if (!keep) req_valid[own] = 1'b0;
    k   = 0;
    cyc = 0;
    while (k < total && cyc < 40 * total + 10) begin
      case (mode)
        0:       beat_ready = 1'b1;
        1:       beat_ready = (cyc % 2 == 0);
        default: beat_ready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      chk("beat_valid", 64'(beat_valid), 64'd1);
      chk("beat_src", 64'(beat_src), 64'(own));
      chk("am_row_or_col", 64'(am_row_or_col), 64'(d.row_or_col));
      chk("am_spad_addr", 64'(am_spad_addr), 64'(d.spad_addr));
      chk("am_num_rows", 64'(am_num_rows), 64'(d.num_rows));
      chk("am_num_cols", 64'(am_num_cols), 64'(d.num_cols));
      chk("am_row_id", 64'(am_row_id), d.row_or_col ? 64'(k) : 64'd0);
      chk("am_col_id", 64'(am_col_id), d.row_or_col ? 64'd0 : 64'(k));
      chk("beat_last", 64'(beat_last), 64'(k == total - 1));
      chk("busy_ready", 64'(req_ready), 64'd0);
      chk("busy_done", 64'(req_done), 64'd0);
      if (beat_ready) k++;
      cyc++;
      @(negedge clk);
    end
    if (k < total) chk("beat_timeout", 64'(k), 64'(total));
    beat_ready = 1'b0;
    #1;
    chk("done_no_beat", 64'(beat_valid), 64'd0);
    chk("done_pulse", 64'(req_done), 64'(oh));
    chk("done_no_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    #1;
    chk("done_one_cycle", 64'(req_done), 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    beat_ready = 1'b0;
    for (int i = 0; i < N; i++) req_desc[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_beat_valid", 64'(beat_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_req_done", 64'(req_done), 64'd0);
    chk("rst_am_fields", {am_row_or_col, am_spad_addr, am_num_rows, am_num_cols, am_row_id, am_col_id}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_quiet", {61'd0, beat_valid, |req_ready, |req_done}, 64'd0);

    // Row-major 4-row tile from requester 0
    req_desc[0] = mk(1'b1, 8, 4, 32);
    req_valid   = 3'b001;
    serve(1'b0, 0);

    // Column-major 3-column tile under a toggling ready
    req_desc[1] = mk(1'b0, 100, 7, 3);
    req_valid   = 3'b010;
    serve(1'b0, 1);

    // Two requesters held valid: grants alternate
    req_desc[0] = mk(1'b1, 20, 2, 9);
    req_desc[1] = mk(1'b0, 40, 9, 2);
    req_valid   = 3'b011;
    repeat (4) serve(1'b1, 0);
    req_valid   = '0;

    // Empty row-major tile: done without any beat
    req_desc[2] = mk(1'b1, 5, 0, 5);
    req_valid   = 3'b100;
    serve(1'b0, 0);

    // Full-width column tile reaches id 31 without wrapping
    req_desc[0] = mk(1'b0, 1023, 1, 32);
    req_valid   = 3'b001;
    serve(1'b0, 0);

    // Reset on the 2nd beat of an 8-beat tile
    req_desc[1] = mk(1'b1, 300, 8, 4);
    req_valid   = 3'b010;
    #1;
    chk("abort_accept", 64'(req_ready), 64'b010);
    @(negedge clk);
    req_valid  = '0;
    beat_ready = 1'b1;
    #1;
    chk("abort_beat0", {62'd0, beat_valid, am_row_id == 5'd0}, 64'b11);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_beat1", {62'd0, beat_valid, am_row_id == 5'd1}, 64'b11);
    @(negedge clk);
    rst        = 1'b0;
    beat_ready = 1'b0;
    #1;
    chk("abort_beat_valid", 64'(beat_valid), 64'd0);
    chk("abort_no_done", 64'(req_done), 64'd0);
    chk("abort_am_addr", 64'(am_spad_addr), 64'd0);
    @(negedge clk);
    #1;
    chk("abort_no_done_later", 64'(req_done), 64'd0);
    model_last = N - 1;
    req_desc[0] = mk(1'b1, 3, 1, 1);
    req_desc[1] = mk(1'b1, 4, 1, 1);
    req_valid   = 3'b011;
    serve(1'b0, 0);
    serve(1'b0, 0);

    // Randomized tiles with random requester sets and random back-pressure
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++) begin
        req_desc[i] = mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
                         ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 32)),
                         ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 32)));
      end
      req_valid = N'($urandom_range(1, (1 << N) - 1));
      serve(1'b0, 2);
    end
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("final_idle", {61'd0, beat_valid, |req_ready, |req_done}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
